// File: rtl/amstrad_mem_pkg.sv
// Shared types and constants for the Amstrad RAM arbitration slice.
package amstrad_mem_pkg;

    // Requester identifiers; the numeric value doubles as the slot index.
    typedef enum logic [1:0] {
        SRC_VID = 2'd0,
        SRC_CPU = 2'd1,
        SRC_LD  = 2'd2
    } src_e;

    // Arbiter sequencing: one RAM transaction in flight at a time.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int RAM_AW = 23;
    localparam int VID_AW = 15;

    // Video memory starts at the bottom of RAM.
    localparam logic [RAM_AW-1:0] VID_BASE = '0;

    // Video fetches are word-indexed; convert the word index to a byte address.
    function automatic logic [RAM_AW-1:0] vid_byte_addr(input logic [VID_AW-1:0] word_idx);
        vid_byte_addr = VID_BASE + {{(RAM_AW-VID_AW-1){1'b0}}, word_idx, 1'b0};
    endfunction

endpackage

// File: rtl/amstrad_req_latch.sv
// Single-entry request slot: captures a request pulse with its payload,
// holds it pending until the arbiter completes it, and records overruns.
module amstrad_req_latch #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req,
    input  logic [W-1:0] din,
    input  logic         done,
    output logic         pending,
    output logic [W-1:0] dout,
    output logic         ovf
);

    logic         pending_reg;
    logic [W-1:0] dout_reg;
    logic         ovf_reg;

    // Capture / complete / overrun bookkeeping. A pulse landing in the
    // completion cycle refills the slot instead of counting as an overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= 1'b0;
            dout_reg    <= '0;
            ovf_reg     <= 1'b0;
        end else if (done) begin
            pending_reg <= req;
            if (req) begin
                dout_reg <= din;
            end
        end else if (pending_reg) begin
            if (req) begin
                ovf_reg <= 1'b1;
            end
        end else if (req) begin
            pending_reg <= 1'b1;
            dout_reg    <= din;
        end
    end

    assign pending = pending_reg;
    assign dout    = dout_reg;
    assign ovf     = ovf_reg;

endmodule

// File: rtl/amstrad_ram_arbiter.sv
// Arbitrates the single SDRAM port between video fetch, CPU and loader.
// Fixed priority video > CPU > loader, with the loader forced in after
// STARVE_LIMIT CPU grants made while it waits.
module amstrad_ram_arbiter
    import amstrad_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [VID_AW-1:0] vid_addr,
    output logic [15:0]       vid_data,
    output logic              vid_valid,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_busy,
    input  logic              ld_wr,
    input  logic [RAM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_busy,
    output logic              ram_req,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [15:0]       ram_rdata,
    input  logic              ram_ack,
    output logic [2:0]        ovf
);

    // CPU slot payload: {we, addr, wdata}; loader slot payload: {addr, data}.
    localparam int CPU_W = 1 + RAM_AW + 8;
    localparam int LD_W  = RAM_AW + 8;
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_e            state_reg, state_next;
    src_e              grant_reg, grant_next;
    src_e              sel;
    logic              ram_req_reg, ram_req_next;
    logic              ram_we_reg, ram_we_next;
    logic [RAM_AW-1:0] ram_addr_reg, ram_addr_next;
    logic [7:0]        ram_wdata_reg, ram_wdata_next;
    logic [15:0]       vid_data_reg, vid_data_next;
    logic              vid_valid_reg, vid_valid_next;
    logic [7:0]        cpu_rdata_reg, cpu_rdata_next;
    logic [7:0]        starve_reg, starve_next;

    logic [2:0]        slot_req;
    logic [2:0]        slot_done;
    logic [2:0]        slot_pending;
    logic [2:0]        slot_ovf;
    logic [VID_AW-1:0] vid_q;
    logic [CPU_W-1:0]  cpu_q;
    logic [LD_W-1:0]   ld_q;

    // A simultaneous read and write from the CPU is captured as a write.
    assign slot_req = {ld_wr, cpu_rd | cpu_wr, vid_req};

    // A slot completes when the SDRAM acks the transaction it owns.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_done
            assign slot_done[gi] = (state_reg == ST_BUSY) && ram_ack && (grant_reg == 2'(gi));
        end
    endgenerate

    amstrad_req_latch #(.W(VID_AW)) u_vid_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (slot_req[SRC_VID]),
        .din     (vid_addr),
        .done    (slot_done[SRC_VID]),
        .pending (slot_pending[SRC_VID]),
        .dout    (vid_q),
        .ovf     (slot_ovf[SRC_VID])
    );

    amstrad_req_latch #(.W(CPU_W)) u_cpu_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (slot_req[SRC_CPU]),
        .din     ({cpu_wr, cpu_addr, cpu_wdata}),
        .done    (slot_done[SRC_CPU]),
        .pending (slot_pending[SRC_CPU]),
        .dout    (cpu_q),
        .ovf     (slot_ovf[SRC_CPU])
    );

    amstrad_req_latch #(.W(LD_W)) u_ld_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (slot_req[SRC_LD]),
        .din     ({ld_addr, ld_data}),
        .done    (slot_done[SRC_LD]),
        .pending (slot_pending[SRC_LD]),
        .dout    (ld_q),
        .ovf     (slot_ovf[SRC_LD])
    );

    // Grant selection from the registered pending state.
    always_comb begin
        sel = SRC_VID;
        if (slot_pending[SRC_VID]) begin
            sel = SRC_VID;
        end else if (slot_pending[SRC_LD] && (starve_reg == STARVE_MAX)) begin
            sel = SRC_LD;
        end else if (slot_pending[SRC_CPU]) begin
            sel = SRC_CPU;
        end else begin
            sel = SRC_LD;
        end
    end

    // Next-state, RAM port drive, starvation counting and read steering.
    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        ram_req_next   = ram_req_reg;
        ram_we_next    = ram_we_reg;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        vid_data_next  = vid_data_reg;
        vid_valid_next = 1'b0;
        cpu_rdata_next = cpu_rdata_reg;
        starve_next    = starve_reg;

        case (state_reg)
            ST_IDLE: begin
                if (|slot_pending) begin
                    state_next   = ST_BUSY;
                    grant_next   = sel;
                    ram_req_next = 1'b1;
                    case (sel)
                        SRC_VID: begin
                            ram_we_next    = 1'b0;
                            ram_addr_next  = vid_byte_addr(vid_q);
                            ram_wdata_next = 8'h00;
                        end
                        SRC_CPU: begin
                            ram_we_next    = cpu_q[CPU_W-1];
                            ram_addr_next  = cpu_q[CPU_W-2:8];
                            ram_wdata_next = cpu_q[7:0];
                            if (slot_pending[SRC_LD] && (starve_reg != STARVE_MAX)) begin
                                starve_next = starve_reg + 8'd1;
                            end
                        end
                        default: begin
                            ram_we_next    = 1'b1;
                            ram_addr_next  = ld_q[LD_W-1:8];
                            ram_wdata_next = ld_q[7:0];
                            starve_next    = 8'd0;
                        end
                    endcase
                end
            end
            default: begin
                // Outputs stay frozen until the controller acknowledges.
                if (ram_ack) begin
                    state_next   = ST_IDLE;
                    ram_req_next = 1'b0;
                    ram_we_next  = 1'b0;
                    if (grant_reg == SRC_VID) begin
                        vid_data_next  = ram_rdata;
                        vid_valid_next = 1'b1;
                    end else if ((grant_reg == SRC_CPU) && !ram_we_reg) begin
                        cpu_rdata_next = ram_addr_reg[0] ? ram_rdata[15:8] : ram_rdata[7:0];
                    end
                end
            end
        endcase

        // The counter only measures an ongoing loader wait.
        if (!slot_pending[SRC_LD]) begin
            starve_next = 8'd0;
        end
    end

    // State and output registers; reset drops any outstanding RAM request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= SRC_VID;
            ram_req_reg   <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= 8'h00;
            vid_data_reg  <= 16'h0000;
            vid_valid_reg <= 1'b0;
            cpu_rdata_reg <= 8'hFF;
            starve_reg    <= 8'd0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            ram_req_reg   <= ram_req_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            vid_data_reg  <= vid_data_next;
            vid_valid_reg <= vid_valid_next;
            cpu_rdata_reg <= cpu_rdata_next;
            starve_reg    <= starve_next;
        end
    end

    assign ram_req   = ram_req_reg;
    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign vid_data  = vid_data_reg;
    assign vid_valid = vid_valid_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign cpu_busy  = slot_pending[SRC_CPU];
    assign ld_busy   = slot_pending[SRC_LD];
    assign ovf       = slot_ovf;

endmodule

// File: doc/amstrad_ram_arbiter.md
# amstrad_ram_arbiter

Shares the single external RAM port between three requesters: video fetch, CPU memory cycles and the ROM/disk loader. Video is 16-bit read-only, the CPU is 8-bit read/write, and the loader is 8-bit write-only. The block sits between the motherboard (vram_addr, mem_addr, mem_rd, mem_wr) and the SDRAM controller. It latches requests, grants by fixed priority with loader anti-starvation, and returns read data to the owning requester.

## Interface
- STARVE_LIMIT, 8: number of consecutive CPU grants made while the loader is pending before the loader is forced in; range 1..255.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- vid_req  in  1  one-cycle pulse: fetch the video word.
- vid_addr  in  15  video word index; RAM byte address is {7'd0, vid_addr, 1'b0}.
- vid_data  out  16  fetched video word.
- vid_valid  out  1  one-cycle pulse when vid_data updates.
- cpu_rd, cpu_wr  in  1  one-cycle pulses; both high in the same cycle is treated as a write.
- cpu_addr  in  23  CPU byte address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read byte.
- cpu_busy  out  1  high from a latched CPU request until its completion.
- ld_wr  in  1  one-cycle loader write pulse.
- ld_addr  in  23  loader byte address.
- ld_data  in  8  loader write data.
- ld_busy  out  1  high while a loader write is pending or in service.
- ram_req  out  1  request to the SDRAM controller; held until ack.
- ram_we  out  1  write qualifier.
- ram_addr  out  23  byte address.
- ram_wdata  out  8  write byte.
- ram_rdata  in  16  read word; valid in the ram_ack cycle.
- ram_ack  in  1  one-cycle completion pulse.
- ovf  out  3  sticky overrun flags {ld, cpu, vid}.

## Operation
- Each source has one pending slot, implemented with amstrad_req_latch.
  - A request pulse captures address and data and sets pending.
  - A pulse that arrives while the slot is already pending is dropped and sets the matching ovf bit.
  - A pulse that arrives in the cycle its own slot completes is captured as the new pending request, and ovf is not set.
- The FSM has two states, IDLE and BUSY.
  - IDLE: if any slot is pending, select a grant, drive ram_req/ram_we/ram_addr/ram_wdata from that slot, and go to BUSY.
  - BUSY: hold the ram_* outputs stable. On ram_ack, clear the granted slot, steer the read data, and return to IDLE.
- Priority: video > CPU > loader, with one exception. If the loader is pending and starve_cnt == STARVE_LIMIT, the loader wins over the CPU. Video always wins.
- starve_cnt:
  - increments on each CPU grant made while the loader is pending, saturating at STARVE_LIMIT;
  - clears on any loader grant;
  - clears whenever the loader is not pending.
- Read steering on ack:
  - video: vid_data <= ram_rdata and vid_valid pulses;
  - CPU read: cpu_rdata <= ram_addr[0] ? ram_rdata[15:8] : ram_rdata[7:0].
- CPU writes drive ram_we=1 and ram_wdata=cpu_wdata; cpu_rdata is left unchanged.
- Loader grants always drive ram_we=1.
- A ram_ack seen in IDLE is ignored.
- ovf bits are cleared only by reset.

## Timing
- Reset values:
  - all ram_* outputs, vid_valid, cpu_busy, ld_busy, ovf, starve_cnt and the pending slots are 0;
  - vid_data = 16'h0000 and cpu_rdata = 8'hFF;
  - the FSM is in IDLE.
- Request pulse at edge N: pending and busy are set at N+1. ram_req is asserted at N+1 at the earliest; the grant is registered from the IDLE decision made using the pending state.
- ram_ack at edge M: ram_req falls at M+1, data outputs update at M+1, and vid_valid is high for exactly the cycle after M+1. A new ram_req may assert at M+2.
- Minimum request-to-data latency is 2 cycles plus SDRAM latency.
- Back-to-back completions therefore have a gap of at least one IDLE cycle.
- cpu_busy and ld_busy fall at M+1 unless a new request for that source was captured in cycle M.
- Asserting reset_n low mid-transfer drops ram_req asynchronously and discards all pending slots. After reset the SDRAM controller must see no outstanding request.

## Structure
- Shared package amstrad_mem_pkg holds:
  - the source enum SRC_VID=0, SRC_CPU=1, SRC_LD=2;
  - RAM_AW=23, VID_AW=15;
  - the video base constant.
- Sub-module amstrad_req_latch (parameter data width) implements the capture/pending/overrun slot. It is instantiated three times.
- The FSM, starvation counter and read steering are in the top level.

## Test plan
- Reset: hold reset_n=0 with ram_ack toggling. All outputs stay at their reset values and cpu_rdata = 8'hFF.
- Video read: vid_req with vid_addr=15'h1234, ack 3 cycles after ram_req with ram_rdata=16'hBEEF. Required: ram_addr=23'h002468, ram_we=0, vid_data=16'hBEEF, and a single vid_valid pulse.
- CPU byte select: cpu_rd with cpu_addr=23'h010001, ram_rdata=16'hA55A. Required: cpu_rdata=8'hA5. Repeat with address 23'h010000; required cpu_rdata=8'h5A.
- Priority: vid_req, cpu_wr and ld_wr in the same cycle. Required grant order is video, CPU, loader, with exactly one IDLE cycle between grants.
- Starvation, STARVE_LIMIT=2: loader pending while the CPU re-requests continuously. Required: the loader is granted after exactly 2 CPU grants, then the CPU resumes.
- Overrun and reset: a second cpu_wr while CPU is pending sets ovf[1] and the first data is written. Pulling reset_n low during BUSY drops ram_req in the same cycle.
